ov_power_seq: RTL and testbench

Camera power-up sequencer. It sits directly downstream of the power-on counter/reset generator; that generator's output drives this block's `rst_n_i`. The block drives the OV sensor power-down and hardware-reset pins through a timed sequence, then starts the SCCB register-configuration engine. It waits for completion, retries on timeout, and reports ready or fail to the video-input path.

---
 rtl/ov_power_seq_if.sv | 40 ++++
 rtl/ov_power_seq.sv | 129 ++++++++++++
 tb/tb_ov_power_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ov_power_seq_if.sv
// Signal bundle between the camera power sequencer and its surroundings:
// the sensor pins, the SCCB configuration handshake and the status lines.
interface ov_power_seq_if;
  logic       restart_i;
  logic       cfg_done_i;
  logic       cfg_err_i;
  logic       cam_pwdn_o;
  logic       cam_rst_n_o;
  logic       cfg_start_o;
  logic       ready_o;
  logic       fail_o;
  logic [2:0] retry_o;
  logic [2:0] state_dg_o;

  modport master (
    input  restart_i,
    input  cfg_done_i,
    input  cfg_err_i,
    output cam_pwdn_o,
    output cam_rst_n_o,
    output cfg_start_o,
    output ready_o,
    output fail_o,
    output retry_o,
    output state_dg_o
  );

  modport slave (
    output restart_i,
    output cfg_done_i,
    output cfg_err_i,
    input  cam_pwdn_o,
    input  cam_rst_n_o,
    input  cfg_start_o,
    input  ready_o,
    input  fail_o,
    input  retry_o,
    input  state_dg_o
  );
endinterface

// File: rtl/ov_power_seq.sv
// OV sensor power-up sequencer: timed PWDN/RESETB release, SCCB config kick-off,
// completion wait with bounded retries, and ready/fail reporting.
module ov_power_seq #(
  parameter logic [23:0] T_PWDN      = 24'd50000,
  parameter logic [23:0] T_RST       = 24'd50000,
  parameter logic [23:0] T_SETTLE    = 24'd100000,
  parameter logic [23:0] CFG_TIMEOUT = 24'd5000000,
  parameter logic [2:0]  MAX_RETRY   = 3'd3
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  ov_power_seq_if.master bus
);

  typedef enum logic [2:0] {
    PWDN     = 3'd0,
    RESET    = 3'd1,
    SETTLE   = 3'd2,
    START    = 3'd3,
    WAIT_CFG = 3'd4,
    READY    = 3'd5,
    FAIL     = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [2:0]  retry_q, retry_d;
  logic        cam_pwdn_q, cam_pwdn_d;
  logic        cam_rst_n_q, cam_rst_n_d;
  logic        cfg_start_q, cfg_start_d;
  logic        ready_q, ready_d;
  logic        fail_q, fail_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= PWDN;
      cnt_q       <= '0;
      retry_q     <= '0;
      cam_pwdn_q  <= 1'b1;
      cam_rst_n_q <= 1'b0;
      cfg_start_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      cam_pwdn_q  <= cam_pwdn_d;
      cam_rst_n_q <= cam_rst_n_d;
      cfg_start_q <= cfg_start_d;
      ready_q     <= ready_d;
      fail_q      <= fail_d;
    end
  end

  // Every state change clears cnt; timed states leave on cnt == T-1 so each lasts T cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 24'd1;
    retry_d = retry_q;
    case (state_q)
      PWDN: begin
        if (cnt_q == T_PWDN - 24'd1) begin
          state_d = RESET;
          cnt_d   = '0;
        end
      end
      RESET: begin
        if (cnt_q == T_RST - 24'd1) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == T_SETTLE - 24'd1) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        state_d = WAIT_CFG;
        cnt_d   = '0;
      end
      WAIT_CFG: begin
        if (bus.cfg_done_i) begin
          state_d = READY;
          cnt_d   = '0;
        end else if (bus.cfg_err_i || (cnt_q == CFG_TIMEOUT - 24'd1)) begin
          cnt_d = '0;
          if (retry_q < MAX_RETRY) begin
            retry_d = retry_q + 3'd1;
            state_d = PWDN;
          end else begin
            state_d = FAIL;
          end
        end
      end
      READY, FAIL: begin
        cnt_d = '0;
        if (bus.restart_i) begin
          state_d = PWDN;
          retry_d = '0;
        end
      end
      default: begin
        state_d = PWDN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the pins move on the same edge as the state.
  always_comb begin
    cam_pwdn_d  = (state_d == PWDN);
    cam_rst_n_d = !((state_d == PWDN) || (state_d == RESET));
    cfg_start_d = (state_d == START);
    ready_d     = (state_d == READY);
    fail_d      = (state_d == FAIL);
  end

  assign bus.cam_pwdn_o  = cam_pwdn_q;
  assign bus.cam_rst_n_o = cam_rst_n_q;
  assign bus.cfg_start_o = cfg_start_q;
  assign bus.ready_o     = ready_q;
  assign bus.fail_o      = fail_q;
  assign bus.retry_o     = retry_q;
  assign bus.state_dg_o  = state_q;

endmodule

// File: tb/tb_ov_power_seq.sv
// Bench for ov_power_seq: directed bring-up scenarios plus random handshake traffic,
// checked every cycle against an elapsed-time model of one power-up attempt.
module tb_ov_power_seq;

  localparam int TP   = 4;
  localparam int TR   = 3;
  localparam int TS   = 5;
  localparam int TO   = 8;
  localparam int MR   = 2;
  localparam int E_ST = TP + TR + TS;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  int   starts;

  // Model: attempt start edge, edges since release, mode (0 sequencing, 1 ready, 2 fail)
  int   m_n;
  int   m_att;
  int   m_mode;
  int   m_retry;

  ov_power_seq_if bus ();

  ov_power_seq #(
    .T_PWDN     (24'd4),
    .T_RST      (24'd3),
    .T_SETTLE   (24'd5),
    .CFG_TIMEOUT(24'd8),
    .MAX_RETRY  (3'd2)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] observed();
    return {bus.state_dg_o, bus.retry_o, bus.fail_o, bus.ready_o,
            bus.cfg_start_o, bus.cam_rst_n_o, bus.cam_pwdn_o};
  endfunction

  function automatic logic [10:0] expected();
    int e;
    logic [2:0] st;
    logic pwdn, rstn, start;
    e     = m_n - m_att;
    pwdn  = 1'b0;
    rstn  = 1'b1;
    start = 1'b0;
    if (m_mode == 1) st = 3'd5;
    else if (m_mode == 2) st = 3'd6;
    else begin
      pwdn  = (e < TP);
      rstn  = !(e < TP + TR);
      start = (e == E_ST);
      if (e < TP) st = 3'd0;
      else if (e < TP + TR) st = 3'd1;
      else if (e < E_ST) st = 3'd2;
      else if (e == E_ST) st = 3'd3;
      else st = 3'd4;
    end
    return {st, 3'(m_retry), (m_mode == 2), (m_mode == 1), start, rstn, pwdn};
  endfunction

  task automatic modelStep(input logic done, input logic err, input logic restart);
    int e;
    e   = m_n - m_att;
    m_n = m_n + 1;
    if (m_mode == 0 && e > E_ST) begin
      if (done) m_mode = 1;
      else if (err || (e - E_ST - 1 == TO - 1)) begin
        if (m_retry < MR) begin
          m_retry = m_retry + 1;
          m_att   = m_n;
        end else m_mode = 2;
      end
    end else if (m_mode != 0 && restart) begin
      m_mode  = 0;
      m_retry = 0;
      m_att   = m_n;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    if (obs !== exp_v) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (edge %0d)", tag, obs, exp_v, m_n);
    end
  endtask

  task automatic applyStimulus(input logic done, input logic err, input logic restart);
    bus.cfg_done_i = done;
    bus.cfg_err_i  = err;
    bus.restart_i  = restart;
    @(posedge clk);
    modelStep(done, err, restart);
    #1;
    if (bus.cfg_start_o) starts++;
    checkOutput("cycle", 32'(observed()), 32'(expected()));
  endtask

  // Reset is asserted and released between edges; outputs must settle with no edge.
  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async", 32'(observed()), 32'h001);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    m_n     = 0;
    m_att   = 0;
    m_mode  = 0;
    m_retry = 0;
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    starts         = 0;
    rst_n          = 1'b0;
    bus.cfg_done_i = 1'b0;
    bus.cfg_err_i  = 1'b0;
    bus.restart_i  = 1'b0;
    m_n = 0; m_att = 0; m_mode = 0; m_retry = 0;

    // Nominal bring-up, done three cycles after the start pulse
    doReset();
    for (int i = 1; i <= 20; i++) begin
      applyStimulus(i == 16, 1'b0, 1'b0);
      if (i == 3)  checkOutput("nom_pwdn_e3", 32'(bus.cam_pwdn_o), 32'd1);
      if (i == 4)  checkOutput("nom_pwdn_e4", 32'(bus.cam_pwdn_o), 32'd0);
      if (i == 6)  checkOutput("nom_rstn_e6", 32'(bus.cam_rst_n_o), 32'd0);
      if (i == 7)  checkOutput("nom_rstn_e7", 32'(bus.cam_rst_n_o), 32'd1);
      if (i == 12) checkOutput("nom_start_e12", 32'(bus.cfg_start_o), 32'd1);
      if (i == 13) checkOutput("nom_start_e13", 32'(bus.cfg_start_o), 32'd0);
      if (i == 15) checkOutput("nom_ready_e15", 32'(bus.ready_o), 32'd0);
      if (i == 16) checkOutput("nom_ready_e16", 32'(bus.ready_o), 32'd1);
    end
    checkOutput("nom_ready_hold", 32'(bus.ready_o), 32'd1);
    checkOutput("nom_retry", 32'(bus.retry_o), 32'd0);

    // Timeout in the first attempt, success in the second
    doReset();
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(i == 36, 1'b0, 1'b0);
      if (i == 20) checkOutput("to_wait_e20", 32'(bus.state_dg_o), 32'd4);
      if (i == 21) checkOutput("to_pwdn_e21", 32'(bus.cam_pwdn_o), 32'd1);
      if (i == 21) checkOutput("to_retry_e21", 32'(bus.retry_o), 32'd1);
      if (i == 36) checkOutput("to_ready_e36", 32'(bus.ready_o), 32'd1);
    end
    checkOutput("to_retry_final", 32'(bus.retry_o), 32'd1);

    // Exhaustion: never done
    doReset();
    starts = 0;
    for (int i = 1; i <= 70; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      if (i == 62) checkOutput("ex_fail_e62", 32'(bus.fail_o), 32'd0);
      if (i == 63) checkOutput("ex_fail_e63", 32'(bus.fail_o), 32'd1);
    end
    checkOutput("ex_starts", 32'(starts), 32'd3);
    checkOutput("ex_fail", 32'(bus.fail_o), 32'd1);
    checkOutput("ex_retry", 32'(bus.retry_o), 32'd2);
    checkOutput("ex_rstn", 32'(bus.cam_rst_n_o), 32'd1);

    // Error retry, done+err priority, restart ignored in SETTLE, done on the last timeout cycle
    doReset();
    for (int i = 1; i <= 53; i++) begin
      applyStimulus((i == 28) || (i == 51), (i == 14) || (i == 28) || (i == 40),
                    (i == 8) || (i == 22) || (i == 30));
      if (i == 8)  checkOutput("pr_settle_ign", 32'(bus.state_dg_o), 32'd2);
      if (i == 14) checkOutput("pr_err_retry", 32'(bus.retry_o), 32'd1);
      if (i == 14) checkOutput("pr_err_pwdn", 32'(bus.state_dg_o), 32'd0);
      if (i == 28) checkOutput("pr_done_wins", 32'(bus.ready_o), 32'd1);
      if (i == 30) checkOutput("pr_restart_st", 32'(bus.state_dg_o), 32'd0);
      if (i == 30) checkOutput("pr_restart_rty", 32'(bus.retry_o), 32'd0);
      if (i == 50) checkOutput("pr_wait_e50", 32'(bus.state_dg_o), 32'd4);
      if (i == 51) checkOutput("pr_done_tmo", 32'(bus.ready_o), 32'd1);
    end
    checkOutput("pr_retry_final", 32'(bus.retry_o), 32'd0);

    // Stale done level held across a restart
    starts = 0;
    for (int i = 1; i <= 20; i++) applyStimulus(1'b1, 1'b0, i == 2);
    checkOutput("stale_starts", 32'(starts), 32'd1);
    checkOutput("stale_ready", 32'(bus.ready_o), 32'd1);

    // Async reset while waiting for configuration, then a full repeat
    doReset();
    for (int i = 1; i <= 15; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("ar_in_wait", 32'(bus.state_dg_o), 32'd4);
    doReset();
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(i == 16, 1'b0, 1'b0);
      if (i == 4) checkOutput("ar_pwdn_e4", 32'(bus.cam_pwdn_o), 32'd0);
    end
    checkOutput("ar_ready", 32'(bus.ready_o), 32'd1);

    // Random handshake traffic
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
